clock_rate_monitor: RTL and testbench

- Receive-side counterpart of the clock divider: takes a divided clock/tick, timed against `clock_in`, and recovers its divisor.
- Per cycle of the incoming signal it measures the period (the divisor) and the high time (duty), and declares lock once the period is stable.
- It flags loss of activity.
- Used by the traffic-light controller to self-check its timebase and to measure external slow clocks.

---
 rtl/clock_rate_monitor_pkg.sv | 24 ++
 rtl/sync_rise_detect.sv | 42 ++++
 rtl/clock_rate_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_clock_rate_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_rate_monitor_pkg.sv
// ---------------------------------------------------------------------------
// clock_rate_monitor_pkg
// Shared definitions for the clock rate monitor: FSM state encoding, the
// default counter width and the saturation ceiling for the cycle counters.
// ---------------------------------------------------------------------------
package clock_rate_monitor_pkg;

  localparam int DEFAULT_CNT_W = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // All-ones value of a counter of the given width (valid for width 1..63).
  function automatic logic [63:0] satMax(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  localparam logic [63:0] CNT_MAX = satMax(DEFAULT_CNT_W);

endpackage

// File: rtl/sync_rise_detect.sv
// ---------------------------------------------------------------------------
// sync_rise_detect
// Two-flop synchronizer for an asynchronous input, followed by a delay
// register used to detect rising edges of the synchronized level.
//
// Ports:
//   i_clk  : sampling clock
//   i_rst  : asynchronous active-high reset, clears all three flops
//   i_sig  : asynchronous input
//   o_sync : synchronized level
//   o_rise : high for one cycle when o_sync goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_rise_detect
  import clock_rate_monitor_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_syncDly;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_syncDly <= 1'b0;
    end else begin
      r_meta    <= i_sig;
      r_sync    <= r_meta;
      r_syncDly <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_syncDly;

endmodule

// File: rtl/clock_rate_monitor.sv
// ---------------------------------------------------------------------------
// clock_rate_monitor
// Measures the period (rising edge to rising edge) and high time of a slow
// divided clock in clock_in cycles, declares lock once the period is stable
// and pulses 'lost' when the signal stops toggling.
//
// Ports:
//   clock_in   : system clock
//   reset      : asynchronous active-high reset
//   sig_in     : monitored signal, may be asynchronous to clock_in
//   period_out : last measured period
//   high_out   : synchronized-high cycles within the last period
//   meas_valid : one-cycle pulse when period_out/high_out update
//   locked     : period stable for LOCK_CNT consecutive comparisons
//   lost       : one-cycle pulse when TIMEOUT cycles pass without a rise
//   duty_err   : (only with DUTY_CHECK_EN) duty differs from the
//                low-first, ceil-high divider split by more than TOL
//
// Optional feature macro: DUTY_CHECK_EN
// ---------------------------------------------------------------------------
module clock_rate_monitor
  import clock_rate_monitor_pkg::*;
#(
  parameter int                 CNT_W    = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0]   TIMEOUT  = 28'd100_000_000,
  parameter int                 LOCK_CNT = 4,
  parameter logic [CNT_W-1:0]   TOL      = '0
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost
`ifdef DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_SAT      = (CNT_W == DEFAULT_CNT_W) ?
                                              CNT_W'(CNT_MAX) : CNT_W'(satMax(CNT_W));
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_W'(1);
  localparam logic [3:0]       LOCK_TARGET  = 4'(LOCK_CNT);

  logic             w_sync;
  logic             w_rise;
  logic [CNT_W-1:0] r_runCnt;
  logic [CNT_W-1:0] r_highCnt;
  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_matchCnt;
  logic [3:0]       w_nextMatch;
  logic             w_publish;
  logic             w_timeout;
  logic [CNT_W-1:0] w_periodDiff;
  logic             w_periodMatch;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_measValid;
  logic             r_locked;
  logic             r_lost;

  sync_rise_detect u_sync (
    .i_clk  (clock_in),
    .i_rst  (reset),
    .i_sig  (sig_in),
    .o_sync (w_sync),
    .o_rise (w_rise)
  );

  // Synchronizer latency is the same at every edge, so counting from one
  // detected rise to the next yields the true period.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_runCnt  <= '0;
      r_highCnt <= '0;
    end else if (w_rise) begin
      r_runCnt  <= CNT_W'(1);
      r_highCnt <= CNT_W'(1);
    end else begin
      if (r_runCnt != CNT_SAT) begin
        r_runCnt <= r_runCnt + CNT_W'(1);
      end
      if (w_sync && (r_highCnt != CNT_SAT)) begin
        r_highCnt <= r_highCnt + CNT_W'(1);
      end
    end
  end

  // Absolute difference without wrap: subtract the smaller from the larger.
  assign w_periodDiff  = (r_runCnt >= r_period) ? (r_runCnt - r_period)
                                                : (r_period - r_runCnt);
  assign w_periodMatch = (w_periodDiff <= TOL);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_matchCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_matchCnt <= w_nextMatch;
    end
  end

  // A rise always takes priority over the timeout on the same edge.
  always_comb begin
    w_nextState = r_state;
    w_nextMatch = r_matchCnt;
    w_publish   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_nextState = ARMED;
        end
      end
      ARMED: begin
        if (w_rise) begin
          w_publish   = 1'b1;
          w_nextMatch = '0;
          w_nextState = MEAS;
        end else if (r_runCnt == TIMEOUT_LAST) begin
          w_timeout = 1'b1;
        end
      end
      MEAS, LOCKED: begin
        if (w_rise) begin
          w_publish = 1'b1;
          if (w_periodMatch) begin
            w_nextMatch = (r_matchCnt >= LOCK_TARGET) ? LOCK_TARGET
                                                      : r_matchCnt + 4'd1;
          end else begin
            w_nextMatch = '0;
          end
          w_nextState = (w_nextMatch >= LOCK_TARGET) ? LOCKED : MEAS;
        end else if (r_runCnt == TIMEOUT_LAST) begin
          w_timeout = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_timeout) begin
      w_nextState = IDLE;
      w_nextMatch = '0;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_period    <= '0;
      r_high      <= '0;
      r_measValid <= 1'b0;
      r_locked    <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_measValid <= w_publish;
      r_lost      <= w_timeout;
      r_locked    <= (w_nextState == LOCKED);
      if (w_publish) begin
        r_period <= r_runCnt;
        r_high   <= r_highCnt;
      end else if (w_timeout) begin
        r_period <= '0;
        r_high   <= '0;
      end
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign meas_valid = r_measValid;
  assign locked     = r_locked;
  assign lost       = r_lost;

`ifdef DUTY_CHECK_EN
  logic [CNT_W-1:0] w_dutyExpect;
  logic [CNT_W-1:0] w_dutyDiff;
  logic             r_dutyErr;

  // The reference divider spends floor(P/2) low and ceil(P/2) high.
  assign w_dutyExpect = r_runCnt - (r_runCnt >> 1);
  assign w_dutyDiff   = (r_highCnt >= w_dutyExpect) ? (r_highCnt - w_dutyExpect)
                                                    : (w_dutyExpect - r_highCnt);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_dutyErr <= 1'b0;
    end else if (w_publish) begin
      r_dutyErr <= (w_dutyDiff > TOL);
    end else if (w_timeout) begin
      r_dutyErr <= 1'b0;
    end
  end

  assign duty_err = r_dutyErr;
`endif

endmodule

// File: tb/tb_clock_rate_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_rate_monitor
// Directed bench for clock_rate_monitor with TIMEOUT=64, LOCK_CNT=4, TOL=0.
// A behavioural divider drives sig_in; its waveform starts each period with
// the high phase so a divisor change takes effect on a rise boundary.
// ---------------------------------------------------------------------------
module tb_clock_rate_monitor;

  logic        clock_in = 1'b0;
  logic        reset    = 1'b1;
  logic        sig_in;
  logic [27:0] period_out;
  logic [27:0] high_out;
  logic        meas_valid;
  logic        locked;
  logic        lost;
`ifdef DUTY_CHECK_EN
  logic        duty_err;
`endif

  int checks    = 0;
  int errors    = 0;
  int srcRises  = 0;
  int lostCount = 0;
  int srcDiv    = 2;
  int srcHi     = 0;
  bit srcEn     = 1'b0;

  always #5 clock_in = ~clock_in;

  clock_rate_monitor #(
    .CNT_W    (28),
    .TIMEOUT  (28'd64),
    .LOCK_CNT (4),
    .TOL      (28'd0)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .locked     (locked),
    .lost       (lost)
`ifdef DUTY_CHECK_EN
    ,
    .duty_err   (duty_err)
`endif
  );

  // Divider model: each period is curHi cycles high then the rest low;
  // the divisor is sampled only at the start of a period.
  initial begin
    int phase;
    int curDiv;
    int curHi;
    phase  = 0;
    curDiv = 2;
    curHi  = 1;
    sig_in = 1'b0;
    forever begin
      @(posedge clock_in);
      #1;
      if (!srcEn) begin
        sig_in = 1'b0;
        phase  = 0;
      end else begin
        if (phase == 0) begin
          curDiv = srcDiv;
          curHi  = (srcHi != 0) ? srcHi : curDiv - curDiv / 2;
          srcRises++;
        end
        sig_in = (phase < curHi);
        phase  = (phase + 1 == curDiv) ? 0 : phase + 1;
      end
    end
  end

  // Counts every lost pulse so a second pulse per loss event is visible.
  always @(negedge clock_in) begin
    if (lost) lostCount++;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Starts (or retargets) the divider model.
  task automatic applyStimulus(input int div, input int hi);
    srcDiv = div;
    srcHi  = hi;
    srcEn  = 1'b1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    srcEn = 1'b0;
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    repeat (2) @(negedge clock_in);
  endtask

  // Advances to the next negedge where meas_valid is high, bounded.
  task automatic waitMeas(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock_in);
      n++;
    end while (!meas_valid && n < 300);
    if (!meas_valid) checkOutput({tag, "_measWait"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int k;
    int base;

    // Reset state
    repeat (3) @(negedge clock_in);
    checkOutput("rst_period", 32'(period_out), 32'd0);
    checkOutput("rst_high",   32'(high_out),   32'd0);
    checkOutput("rst_valid",  32'(meas_valid), 32'd0);
    checkOutput("rst_locked", 32'(locked),     32'd0);
    checkOutput("rst_lost",   32'(lost),       32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock_in);

    // Divide-by-2: measurement from the 2nd rise, lock on the 6th
    applyStimulus(2, 0);
    for (int i = 1; i <= 5; i++) begin
      waitMeas("div2");
      checkOutput("div2_period", 32'(period_out), 32'd2);
      checkOutput("div2_high",   32'(high_out),   32'd1);
      checkOutput("div2_locked", 32'(locked),     (i == 5) ? 32'd1 : 32'd0);
    end

    // Divide-by-5: ceil-high split gives high time 3
    applyReset();
    applyStimulus(5, 0);
    for (int i = 1; i <= 5; i++) begin
      waitMeas("div5");
      checkOutput("div5_period", 32'(period_out), 32'd5);
      checkOutput("div5_high",   32'(high_out),   32'd3);
      checkOutput("div5_locked", 32'(locked),     (i == 5) ? 32'd1 : 32'd0);
`ifdef DUTY_CHECK_EN
      checkOutput("div5_dutyErr", 32'(duty_err), 32'd0);
`endif
    end

    // Switch 5 -> 7: lock drops on the first 7-period, returns after 4 matches
    applyStimulus(7, 0);
    k = 0;
    do begin
      waitMeas("div7sw");
      k++;
    end while (period_out == 28'd5 && k < 4);
    checkOutput("div7_firstPeriod", 32'(period_out), 32'd7);
    checkOutput("div7_firstHigh",   32'(high_out),   32'd4);
    checkOutput("div7_firstLocked", 32'(locked),     32'd0);
    for (int i = 1; i <= 4; i++) begin
      waitMeas("div7");
      checkOutput("div7_period", 32'(period_out), 32'd7);
      checkOutput("div7_locked", 32'(locked),     (i == 4) ? 32'd1 : 32'd0);
    end

    // Loss of activity: lost is high in the 64th cycle counting the
    // meas_valid cycle of the last rise as the first
    base  = lostCount;
    srcEn = 1'b0;
    n = 0;
    do begin
      @(negedge clock_in);
      n++;
    end while (!lost && n < 300);
    checkOutput("lost_delay",  32'(n),          32'd63);
    checkOutput("lost_period", 32'(period_out), 32'd0);
    checkOutput("lost_high",   32'(high_out),   32'd0);
    checkOutput("lost_locked", 32'(locked),     32'd0);
    repeat (100) @(negedge clock_in);
    checkOutput("lost_once", 32'(lostCount - base), 32'd1);

    // After a loss the first rise only arms
    srcRises = 0;
    applyStimulus(5, 0);
    waitMeas("rearm");
    checkOutput("rearm_rises",  32'(srcRises),   32'd2);
    checkOutput("rearm_period", 32'(period_out), 32'd5);

    // Asynchronous reset between clock edges while measuring
    @(negedge clock_in);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_period", 32'(period_out), 32'd0);
    checkOutput("async_high",   32'(high_out),   32'd0);
    checkOutput("async_valid",  32'(meas_valid), 32'd0);
    srcEn = 1'b0;
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    repeat (2) @(negedge clock_in);
    srcRises = 0;
    applyStimulus(5, 0);
    waitMeas("postRst");
    checkOutput("postRst_rises",  32'(srcRises),   32'd2);
    checkOutput("postRst_period", 32'(period_out), 32'd5);

    // Period of exactly TIMEOUT-1: the rise wins over the timeout
    base = lostCount;
    applyStimulus(63, 0);
    k = 0;
    do begin
      waitMeas("div63");
      k++;
    end while (period_out == 28'd5 && k < 4);
    checkOutput("div63_period", 32'(period_out), 32'd63);
    checkOutput("div63_high",   32'(high_out),   32'd32);
    waitMeas("div63b");
    checkOutput("div63_period2", 32'(period_out),        32'd63);
    checkOutput("div63_noLost",  32'(lostCount - base),  32'd0);

    // Period of TIMEOUT: activity is declared lost
    applyStimulus(64, 0);
    n = 0;
    do begin
      @(negedge clock_in);
      n++;
    end while (!lost && n < 300);
    checkOutput("div64_lost",   32'(lost),       32'd1);
    checkOutput("div64_period", 32'(period_out), 32'd0);

`ifdef DUTY_CHECK_EN
    // One high cycle in eight: far from the 4-cycle reference high time
    applyReset();
    applyStimulus(8, 1);
    waitMeas("duty");
    checkOutput("duty_period", 32'(period_out), 32'd8);
    checkOutput("duty_high",   32'(high_out),   32'd1);
    checkOutput("duty_err",    32'(duty_err),   32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
